group_serial_adder: RTL and testbench

Multi-cycle parametrised adder/subtractor for the datapath. It processes a WIDTH-bit operand pair GROUP bits per clock, using one lookahead slice built from the generate/propagate carry-group equation (c_out = g | (p & c_in)). The carry is held in a register between slices. The block feeds the AC/E update path and trades latency for area, with a start/busy/done handshake.

---
 rtl/group_serial_adder_pkg.sv | 15 +
 rtl/group_serial_adder_carry_lookahead_slice.sv | 32 +++
 rtl/group_serial_adder.sv | 137 +++++++++++++
 tb/tb_group_serial_adder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/group_serial_adder_pkg.sv
// Shared types and helpers for the group-serial adder/subtractor.
package group_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that must hold 0..n-1; a single slice still needs one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/group_serial_adder_carry_lookahead_slice.sv
// Combinational GROUP-bit slice: per-bit generate/propagate with the carry-group equation.
module carry_lookahead_slice #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a_s,
    input  logic [GROUP-1:0] b_s,
    input  logic             c_in,
    output logic [GROUP-1:0] s,
    output logic             c_out,
    output logic             c_msb
);

    logic [GROUP-1:0] w_p;
    logic [GROUP-1:0] w_g;
    logic [GROUP:0]   w_c;

    assign w_p = a_s ^ b_s;
    assign w_g = a_s & b_s;

    always_comb begin
        w_c    = '0;
        w_c[0] = c_in;
        for (int i = 0; i < GROUP; i++) begin
            w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
        end
    end

    assign s     = w_p ^ w_c[GROUP-1:0];
    assign c_out = w_c[GROUP];
    assign c_msb = w_c[GROUP-1];

endmodule

// File: rtl/group_serial_adder.sv
// Multi-cycle adder/subtractor: one GROUP-bit slice per clock, carry held between slices.
module group_serial_adder
    import group_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int SAFE_GROUP = (GROUP < 1) ? 1 : GROUP;
    localparam int NSLICE     = WIDTH / SAFE_GROUP;
    localparam int IDXW       = idx_width(NSLICE);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    generate
        if ((GROUP < 1) || (GROUP > WIDTH) || ((WIDTH % SAFE_GROUP) != 0)) begin : g_bad_params
            $error("group_serial_adder: WIDTH must be a positive multiple of GROUP");
        end
    endgenerate

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic             w_last;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_sum;
    logic             r_c_out;
    logic             r_ovf;

    logic [GROUP-1:0] w_a_s;
    logic [GROUP-1:0] w_b_s;
    logic [GROUP-1:0] w_s;
    logic             w_c_out;
    logic             w_c_msb;

    assign w_last = (r_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // DONE accepts a new start exactly like IDLE so operations can run back-to-back.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next   = RUN;
                    w_accept = 1'b1;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_next   = RUN;
                    w_accept = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_a_s = r_a[r_idx*GROUP +: GROUP];
    assign w_b_s = r_b[r_idx*GROUP +: GROUP];

    carry_lookahead_slice #(
        .GROUP (GROUP)
    ) u_slice (
        .a_s   (w_a_s),
        .b_s   (w_b_s),
        .c_in  (r_carry),
        .s     (w_s),
        .c_out (w_c_out),
        .c_msb (w_c_msb)
    );

    // Subtraction is folded into the operands at capture: a + ~b + 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : c_in;
            r_idx   <= '0;
            r_sum   <= '0;
        end else if (r_state == RUN) begin
            r_sum[r_idx*GROUP +: GROUP] <= w_s;
            r_carry <= w_c_out;
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
                r_c_out <= w_c_out;
                r_ovf   <= w_c_out ^ w_c_msb;
            end
        end
    end

    assign busy     = (r_state == RUN);
    assign done     = (r_state == DONE);
    assign sum      = r_sum;
    assign c_out    = r_c_out;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_group_serial_adder.sv
// Directed bench for group_serial_adder with three slice widths and a result scoreboard.
module tb_group_serial_adder;

    logic        clk;
    logic        reset;
    logic        start4, start16, start1;
    logic        sub_i;
    logic [15:0] a_i, b_i;
    logic        c_in_i;

    logic        busy4, done4, cout4, ovf4;
    logic        busy16, done16, cout16, ovf16;
    logic        busy1, done1, cout1, ovf1;
    logic [15:0] sum4, sum16, sum1;

    logic [17:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    group_serial_adder #(.WIDTH(16), .GROUP(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .sub(sub_i), .a(a_i), .b(b_i), .c_in(c_in_i),
        .busy(busy4), .done(done4), .sum(sum4), .c_out(cout4), .overflow(ovf4)
    );

    group_serial_adder #(.WIDTH(16), .GROUP(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .sub(sub_i), .a(a_i), .b(b_i), .c_in(c_in_i),
        .busy(busy16), .done(done16), .sum(sum16), .c_out(cout16), .overflow(ovf16)
    );

    group_serial_adder #(.WIDTH(16), .GROUP(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .sub(sub_i), .a(a_i), .b(b_i), .c_in(c_in_i),
        .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1), .overflow(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: {c_out, overflow, sum}; overflow from carry into bit 15 vs carry out.
    function automatic logic [17:0] model(input logic s, input logic [15:0] aa, input logic [15:0] bb,
                                          input logic ci);
        logic [15:0] bx;
        logic        cx;
        logic [16:0] full;
        logic [15:0] low;
        bx   = s ? ~bb : bb;
        cx   = s ? 1'b1 : ci;
        full = {1'b0, aa} + {1'b0, bx} + {16'd0, cx};
        low  = {1'b0, aa[14:0]} + {1'b0, bx[14:0]} + {15'd0, cx};
        return {full[16], full[16] ^ low[15], full[15:0]};
    endfunction

    // {busy, done, c_out, overflow, sum}
    function automatic logic [19:0] outs(input int which);
        case (which)
            0:       return {busy4, done4, cout4, ovf4, sum4};
            1:       return {busy16, done16, cout16, ovf16, sum16};
            default: return {busy1, done1, cout1, ovf1, sum1};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int which, input logic v);
        case (which)
            0:       start4  = v;
            1:       start16 = v;
            default: start1  = v;
        endcase
    endtask

    task automatic start_op(input int which, input logic s, input logic [15:0] aa, input logic [15:0] bb,
                            input logic ci);
        sub_i  = s;
        a_i    = aa;
        b_i    = bb;
        c_in_i = ci;
        set_start(which, 1'b1);
        exp_q.push_back(model(s, aa, bb, ci));
    endtask

    task automatic check_result(input string tag, input logic [17:0] obs);
        logic [17:0] e;
        if (exp_q.size() == 0) begin
            check({tag, ":queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, ":result"}, {14'd0, obs}, {14'd0, e});
        end
    endtask

    task automatic wait_done(input int which, input int exp_lat, input int exp_busy, input string tag);
        int          cnt;
        int          bc;
        bit          got;
        logic [19:0] o;
        cnt = 0;
        bc  = 0;
        got = 1'b0;
        o   = '0;
        while (!got && cnt < 60) begin
            @(negedge clk);
            if (cnt == 0) set_start(which, 1'b0);
            cnt++;
            o = outs(which);
            if (o[19]) bc++;
            if (o[18]) got = 1'b1;
        end
        check({tag, ":done_seen"}, {31'd0, got}, 32'd1);
        if (got) begin
            check({tag, ":latency"}, cnt, exp_lat);
            check({tag, ":busy_cycles"}, bc, exp_busy);
            check_result(tag, o[17:0]);
            @(negedge clk);
            o = outs(which);
            check({tag, ":done_pulse"}, {31'd0, o[18]}, 32'd0);
        end else if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end
    endtask

    initial begin : stim
        int          cnt;
        bit          got;
        logic [19:0] o;

        reset   = 1'b1;
        start4  = 1'b0;
        start16 = 1'b0;
        start1  = 1'b0;
        sub_i   = 1'b0;
        a_i     = '0;
        b_i     = '0;
        c_in_i  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int w = 0; w < 3; w++) begin
            check($sformatf("reset_state_%0d", w), {12'd0, outs(w)}, 32'd0);
        end

        // Basic add, carry wrap, signed overflow
        start_op(0, 1'b0, 16'h00FF, 16'h0001, 1'b0);
        wait_done(0, 5, 4, "add_basic");
        start_op(0, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
        wait_done(0, 5, 4, "add_wrap");
        start_op(0, 1'b0, 16'h7FFF, 16'h0001, 1'b0);
        wait_done(0, 5, 4, "add_ovf");
        start_op(0, 1'b0, 16'h1000, 16'h2000, 1'b1);
        wait_done(0, 5, 4, "add_cin");

        // Subtract with borrow and without; c_in must be ignored
        start_op(0, 1'b1, 16'h0005, 16'h0007, 1'b1);
        wait_done(0, 5, 4, "sub_borrow");
        start_op(0, 1'b1, 16'h0007, 16'h0005, 1'b0);
        wait_done(0, 5, 4, "sub_noborrow");
        start_op(0, 1'b1, 16'h8000, 16'h0001, 1'b0);
        wait_done(0, 5, 4, "sub_ovf");

        // Start held through RUN with changing operands, then back-to-back from DONE
        start_op(0, 1'b0, 16'h1111, 16'h2222, 1'b0);
        cnt = 0;
        got = 1'b0;
        o   = '0;
        while (!got && cnt < 60) begin
            @(negedge clk);
            cnt++;
            o = outs(0);
            if (o[18]) begin
                got = 1'b1;
            end else begin
                a_i    = 16'($urandom_range(0, 65535));
                b_i    = 16'($urandom_range(0, 65535));
                c_in_i = 1'($urandom_range(0, 1));
            end
        end
        check("hold:done_seen", {31'd0, got}, 32'd1);
        check("hold:latency", cnt, 5);
        check_result("hold", o[17:0]);
        start_op(0, 1'b1, 16'h0007, 16'h0005, 1'b0);
        @(negedge clk);
        start4 = 1'b0;
        o = outs(0);
        check("b2b:no_idle_gap", {30'd0, o[19:18]}, 32'd2);
        cnt = 1;
        got = 1'b0;
        while (!got && cnt < 60) begin
            @(negedge clk);
            cnt++;
            o = outs(0);
            if (o[18]) got = 1'b1;
        end
        check("b2b:done_seen", {31'd0, got}, 32'd1);
        check("b2b:done_spacing", cnt, 5);
        check_result("b2b", o[17:0]);

        // Reset on the second RUN cycle aborts the operation and clears outputs
        sub_i  = 1'b0;
        a_i    = 16'hFFFF;
        b_i    = 16'hFFFF;
        c_in_i = 1'b1;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        check("abort:busy_before", {31'd0, busy4}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort:outputs_cleared", {12'd0, outs(0)}, 32'd0);
        @(negedge clk);
        check("abort:stays_idle", {31'd0, busy4}, 32'd0);
        start_op(0, 1'b0, 16'h1234, 16'h1111, 1'b0);
        wait_done(0, 5, 4, "after_abort");

        // Random operations on the GROUP=4 instance
        for (int i = 0; i < 6; i++) begin
            start_op(0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
                     16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
            wait_done(0, 5, 4, $sformatf("rand4_%0d", i));
        end

        // Single-slice and bit-serial configurations
        start_op(1, 1'b0, 16'h7FFF, 16'h0001, 1'b0);
        wait_done(1, 2, 1, "g16_ovf");
        start_op(1, 1'b1, 16'h0005, 16'h0007, 1'b0);
        wait_done(1, 2, 1, "g16_sub");
        start_op(2, 1'b0, 16'hFFFF, 16'h0000, 1'b1);
        wait_done(2, 17, 16, "g1_cin_wrap");
        start_op(2, 1'b0, 16'h7FFF, 16'h0001, 1'b0);
        wait_done(2, 17, 16, "g1_ovf");
        for (int i = 0; i < 3; i++) begin
            start_op(2, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
                     16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
            wait_done(2, 17, 16, $sformatf("rand1_%0d", i));
        end

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
